// File: rtl/uart_status_tx.sv
// Status-frame UART transmitter: snapshots the video status inputs on request and
// sends a fixed 10-byte 8N1 frame (sync, geometry, mode, checksum, CR).
module uart_status_tx #(
   parameter int CLK_FREQ = 24_000_000,
   parameter int BAUD     = 115200
) (
   input  logic        sys_clk_24M,
   input  logic        sys_rst,
   input  logic        report_req,
   input  logic [11:0] x_pix_len,
   input  logic [11:0] y_pix_len,
   input  logic [1:0]  out_model,
   input  logic [8:0]  bi_a,
   input  logic        vid_format,
   input  logic        cfg_done,
   output logic        fpga_txd,
   output logic        busy,
   output logic        frame_done
);

   // state | meaning
   // IDLE  | line high, waiting for a new or pending request
   // LOAD  | snapshot held, checksum being registered
   // START | start bit (0) of the current byte
   // DATA  | 8 data bits, LSB first
   // STOP  | stop bit (1); last byte returns to IDLE

   localparam int BIT_CYC = CLK_FREQ / BAUD;
   localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam logic [CW-1:0] BAUD_TC = CW'(BIT_CYC - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [3:0]    byte_idx;
   logic          pending;
   logic          frame_done_q;

   logic [11:0]   x_q, y_q;
   logic [1:0]    om_q;
   logic [8:0]    bi_q;
   logic          vf_q, cd_q;
   logic [7:0]    csum_q;

   logic [7:0]    b2, b3, b4, b5, b6, b7;
   logic [7:0]    csum_nxt;
   logic [7:0]    cur_byte;
   logic          in_frame, baud_tick, accept, last_stop;
   logic          txd_c;

   assign b2 = {4'b0, x_q[11:8]};
   assign b3 = x_q[7:0];
   assign b4 = {4'b0, y_q[11:8]};
   assign b5 = y_q[7:0];
   assign b6 = {3'b0, vf_q, cd_q, om_q, bi_q[8]};
   assign b7 = bi_q[7:0];
   assign csum_nxt = b2 + b3 + b4 + b5 + b6 + b7;

   assign in_frame  = (state == START) || (state == DATA) || (state == STOP);
   assign baud_tick = in_frame && (baud_cnt == BAUD_TC);
   assign accept    = (state == IDLE) && (report_req || pending);
   assign last_stop = (state == STOP) && baud_tick && (byte_idx == 4'd9);

   always_comb begin
      cur_byte = 8'h0D;
      case (byte_idx)
         4'd0:    cur_byte = 8'h55;
         4'd1:    cur_byte = 8'hAA;
         4'd2:    cur_byte = b2;
         4'd3:    cur_byte = b3;
         4'd4:    cur_byte = b4;
         4'd5:    cur_byte = b5;
         4'd6:    cur_byte = b6;
         4'd7:    cur_byte = b7;
         4'd8:    cur_byte = csum_q;
         default: cur_byte = 8'h0D;
      endcase
   end

   always_comb begin
      state_nxt = state;
      txd_c     = 1'b1;
      case (state)
         IDLE:  if (accept) state_nxt = LOAD;
         LOAD:  state_nxt = START;
         START: begin
            txd_c = 1'b0;
            if (baud_tick) state_nxt = DATA;
         end
         DATA: begin
            txd_c = cur_byte[bit_idx];
            if (baud_tick && (bit_idx == 3'd7)) state_nxt = STOP;
         end
         STOP: begin
            if (baud_tick) state_nxt = (byte_idx == 4'd9) ? IDLE : START;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_24M) begin
      if (sys_rst) begin
         state        <= IDLE;
         baud_cnt     <= '0;
         bit_idx      <= '0;
         byte_idx     <= '0;
         pending      <= 1'b0;
         frame_done_q <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         om_q         <= '0;
         bi_q         <= '0;
         vf_q         <= 1'b0;
         cd_q         <= 1'b0;
         csum_q       <= '0;
      end else begin
         state        <= state_nxt;
         frame_done_q <= last_stop;

         // A request seen outside IDLE (including the last stop cycle) is held once.
         if (accept)
            pending <= 1'b0;
         else if (report_req && (state != IDLE))
            pending <= 1'b1;

         if (accept) begin
            x_q  <= x_pix_len;
            y_q  <= y_pix_len;
            om_q <= out_model;
            bi_q <= bi_a;
            vf_q <= vid_format;
            cd_q <= cfg_done;
         end

         if (state == LOAD) csum_q <= csum_nxt;

         if (in_frame)
            baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
         else
            baud_cnt <= '0;

         if (!in_frame)
            bit_idx <= '0;
         else if ((state == DATA) && baud_tick)
            bit_idx <= (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;

         if (!in_frame)
            byte_idx <= '0;
         else if ((state == STOP) && baud_tick)
            byte_idx <= (byte_idx == 4'd9) ? 4'd0 : byte_idx + 4'd1;
      end
   end

   // Reset overrides the outputs immediately so the line is idle while reset is held.
   assign fpga_txd   = sys_rst ? 1'b1 : txd_c;
   assign busy       = !sys_rst && (state != IDLE);
   assign frame_done = !sys_rst && frame_done_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: decodes the serial line cycle by cycle and compares each
// frame against bytes computed arithmetically from the inputs at request time.
module tb_uart_status_tx;

   localparam int TB_CLK_FREQ = 24_000_000;
   localparam int TB_BAUD     = 1_400_000;
   localparam int BIT_CYC     = 17;            // 24e6 / 1.4e6 = 17.14, truncated
   localparam int BYTE_CYC    = 10 * BIT_CYC;
   localparam int FRAME_CYC   = 100 * BIT_CYC;

   logic        sys_clk_24M = 1'b0;
   logic        sys_rst;
   logic        report_req;
   logic [11:0] x_pix_len;
   logic [11:0] y_pix_len;
   logic [1:0]  out_model;
   logic [8:0]  bi_a;
   logic        vid_format;
   logic        cfg_done;
   logic        fpga_txd;
   logic        busy;
   logic        frame_done;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] exp_b [10];

   uart_status_tx #(.CLK_FREQ(TB_CLK_FREQ), .BAUD(TB_BAUD)) dut (
      .sys_clk_24M (sys_clk_24M),
      .sys_rst     (sys_rst),
      .report_req  (report_req),
      .x_pix_len   (x_pix_len),
      .y_pix_len   (y_pix_len),
      .out_model   (out_model),
      .bi_a        (bi_a),
      .vid_format  (vid_format),
      .cfg_done    (cfg_done),
      .fpga_txd    (fpga_txd),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   always #5 sys_clk_24M = ~sys_clk_24M;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference frame from the current inputs, using plain arithmetic.
   task automatic set_exp();
      int s;
      exp_b[0] = 8'h55;
      exp_b[1] = 8'hAA;
      exp_b[2] = 8'(int'(x_pix_len) / 256);
      exp_b[3] = 8'(int'(x_pix_len) % 256);
      exp_b[4] = 8'(int'(y_pix_len) / 256);
      exp_b[5] = 8'(int'(y_pix_len) % 256);
      exp_b[6] = 8'(int'(vid_format) * 16 + int'(cfg_done) * 8 + int'(out_model) * 2
                    + int'(bi_a) / 256);
      exp_b[7] = 8'(int'(bi_a) % 256);
      s = 0;
      for (int i = 2; i <= 7; i++) s += int'(exp_b[i]);
      exp_b[8] = 8'(s % 256);
      exp_b[9] = 8'h0D;
   endtask

   // Called at a negedge with the DUT idle; returns at the first start-bit cycle.
   task automatic send_req();
      report_req = 1'b1;
      @(negedge sys_clk_24M);
      report_req = 1'b0;
      chk("lat_busy", 32'(busy), 32'd1);
      chk("lat_txd_hi", 32'(fpga_txd), 32'd1);
      @(negedge sys_clk_24M);
      chk("lat_start", 32'(fpga_txd), 32'd0);
   endtask

   // mode: 0 plain, 1 change x in byte 2, 2 three requests mid-frame, 3 reset in byte 4
   // after_end: 0 expect idle, 1 expect pending frame, 2 request coincident with frame_done
   task automatic rx_frame(input int mode, input int after_end);
      logic [99:0] bitv;
      logic        first;
      int          glitch, busy_bad, fd_bad, ferr, bad;
      bit          aborted;
      bitv = '0; first = 1'b1;
      glitch = 0; busy_bad = 0; fd_bad = 0; ferr = 0; bad = 0; aborted = 1'b0;
      for (int t = 0; t < FRAME_CYC && !aborted; t++) begin
         if (t > 0) @(negedge sys_clk_24M);
         if (t % BIT_CYC == 0) begin
            first = fpga_txd;
            bitv[t / BIT_CYC] = fpga_txd;
         end else if (fpga_txd !== first) glitch++;
         if (busy !== 1'b1) busy_bad++;
         if (frame_done !== 1'b0) fd_bad++;
         case (mode)
            1: if (t == 2 * BYTE_CYC + 3) x_pix_len = 12'd640;
            2: begin
               report_req = (t == 5 * BYTE_CYC) || (t == 6 * BYTE_CYC + 7) || (t == 9 * BYTE_CYC);
               if (t == 9 * BYTE_CYC + 20) y_pix_len = y_pix_len + 12'd1;
            end
            3: if (t == 4 * BYTE_CYC + 5) aborted = 1'b1;
            default: ;
         endcase
      end
      chk("busy_in_frame", 32'(busy_bad), 32'd0);
      chk("fd_in_frame", 32'(fd_bad), 32'd0);
      if (aborted) begin
         sys_rst = 1'b1;
         @(negedge sys_clk_24M);
         chk("abort_txd", 32'(fpga_txd), 32'd1);
         chk("abort_busy", 32'(busy), 32'd0);
         chk("abort_fd", 32'(frame_done), 32'd0);
         @(negedge sys_clk_24M);
         sys_rst = 1'b0;
         for (int t = 0; t < FRAME_CYC; t++) begin
            @(negedge sys_clk_24M);
            if (busy !== 1'b0 || frame_done !== 1'b0 || fpga_txd !== 1'b1) bad++;
         end
         chk("abort_quiet", 32'(bad), 32'd0);
         return;
      end
      chk("bit_width", 32'(glitch), 32'd0);
      for (int i = 0; i < 10; i++) begin
         if (bitv[10 * i] !== 1'b0 || bitv[10 * i + 9] !== 1'b1) ferr++;
         chk($sformatf("byte%0d", i), 32'(bitv[10 * i + 1 +: 8]), 32'(exp_b[i]));
      end
      chk("framing", 32'(ferr), 32'd0);
      @(negedge sys_clk_24M);
      chk("end_fd", 32'(frame_done), 32'd1);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_txd", 32'(fpga_txd), 32'd1);
      if (after_end == 0) begin
         @(negedge sys_clk_24M);
         chk("fd_pulse", 32'(frame_done), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
      end else begin
         if (after_end == 2) report_req = 1'b1;
         @(negedge sys_clk_24M);
         report_req = 1'b0;
         chk("next_busy", 32'(busy), 32'd1);
         chk("next_fd", 32'(frame_done), 32'd0);
         @(negedge sys_clk_24M);
         chk("next_start", 32'(fpga_txd), 32'd0);
      end
   endtask

   initial begin
      int bad;
      sys_rst = 1'b1; report_req = 1'b0;
      x_pix_len = 12'd1920; y_pix_len = 12'd1080; out_model = 2'd1;
      bi_a = 9'd128; vid_format = 1'b0; cfg_done = 1'b1;
      repeat (3) @(negedge sys_clk_24M);
      chk("rst_txd", 32'(fpga_txd), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      sys_rst = 1'b0;
      repeat (5) @(negedge sys_clk_24M);
      chk("idle_txd", 32'(fpga_txd), 32'd1);
      chk("idle_busy0", 32'(busy), 32'd0);

      // Basic frame with literal expected bytes
      exp_b = '{8'h55, 8'hAA, 8'h07, 8'h80, 8'h04, 8'h38, 8'h0A, 8'h80, 8'h4D, 8'h0D};
      send_req();
      rx_frame(0, 0);

      // Snapshot: x change mid-frame only shows up in the next frame
      set_exp();
      send_req();
      rx_frame(1, 0);
      set_exp();
      chk("snap_x_hi", 32'(exp_b[2]), 32'h02);
      send_req();
      rx_frame(0, 0);

      // Three requests during a frame give exactly one more frame with a fresh snapshot
      set_exp();
      send_req();
      rx_frame(2, 1);
      set_exp();
      rx_frame(0, 0);
      bad = 0;
      repeat (3 * BIT_CYC) begin
         @(negedge sys_clk_24M);
         if (busy !== 1'b0 || fpga_txd !== 1'b1) bad++;
      end
      chk("no_third_frame", 32'(bad), 32'd0);

      // Request coincident with frame_done
      set_exp();
      send_req();
      rx_frame(0, 2);
      set_exp();
      rx_frame(0, 0);

      // Checksum wrap: bytes 2..7 sum to 0x33A, so the checksum byte is 0x3A
      x_pix_len = 12'hFFF; y_pix_len = 12'hFFF; out_model = 2'd3;
      bi_a = 9'h1FF; vid_format = 1'b1; cfg_done = 1'b1;
      set_exp();
      send_req();
      rx_frame(0, 0);

      // Reset during byte 4, then a clean frame
      x_pix_len = 12'd1920; y_pix_len = 12'd1080; out_model = 2'd1;
      bi_a = 9'd128; vid_format = 1'b0; cfg_done = 1'b1;
      set_exp();
      send_req();
      rx_frame(3, 0);
      set_exp();
      send_req();
      rx_frame(0, 0);

      // Random status values
      for (int r = 0; r < 4; r++) begin
         x_pix_len  = 12'($urandom);
         y_pix_len  = 12'($urandom);
         out_model  = 2'($urandom);
         bi_a       = 9'($urandom);
         vid_format = 1'($urandom);
         cfg_done   = 1'($urandom);
         set_exp();
         send_req();
         rx_frame(0, 0);
         repeat ($urandom_range(1, 5)) @(negedge sys_clk_24M);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
